// File: rtl/chess_turn_ctrl.sv
// Turn controller for a two-player chess clock: selects the running side, counts
// down on the 1 Hz tick, applies the per-move increment and flags time-outs.
module chess_turn_ctrl #(
  parameter int TIME_W    = 12,
  parameter int INIT_TIME = 300,
  parameter int INC       = 2
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              TICK,
  input  logic              START,
  input  logic              BTN_A,
  input  logic              BTN_B,
  input  logic              PAUSE,
  output logic [TIME_W-1:0] TIME_A,
  output logic [TIME_W-1:0] TIME_B,
  output logic              ACTIVE_A,
  output logic              ACTIVE_B,
  output logic              FLAG_A,
  output logic              FLAG_B,
  output logic              PRE_CE,
  output logic              PRE_CLR
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN_A  = 3'd1,
    RUN_B  = 3'd2,
    PAUSED = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [TIME_W-1:0] INIT_V = TIME_W'(INIT_TIME);
  localparam logic [TIME_W-1:0] ONE_V  = TIME_W'(1);
  localparam logic [TIME_W+1:0] INC_V  = (TIME_W+2)'(INC);
  localparam logic [TIME_W+1:0] MAX_V  = {2'b00, {TIME_W{1'b1}}};

  state_t              state_r, state_nx_s;
  logic                resume_b_r, resume_b_nx_s;
  logic [TIME_W-1:0]   time_a_nx_s, time_b_nx_s;
  logic                flag_a_nx_s, flag_b_nx_s, pre_clr_nx_s;

  // Mover's time after handing over: minus a coincident tick, plus increment, saturating.
  function automatic logic [TIME_W-1:0] add_inc(input logic [TIME_W-1:0] t, input logic tick);
    logic [TIME_W+1:0] sum;
    sum = {2'b00, t} - {{(TIME_W+1){1'b0}}, tick} + INC_V;
    if (sum > MAX_V) return {TIME_W{1'b1}};
    else             return sum[TIME_W-1:0];
  endfunction

  // Next-state and next-output decode; first matching rule wins in each state.
  always_comb begin
    state_nx_s    = state_r;
    resume_b_nx_s = resume_b_r;
    time_a_nx_s   = TIME_A;
    time_b_nx_s   = TIME_B;
    flag_a_nx_s   = FLAG_A;
    flag_b_nx_s   = FLAG_B;
    pre_clr_nx_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (START) begin
          state_nx_s   = RUN_A;
          pre_clr_nx_s = ~PRE_CLR;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN_A: begin
        if (PAUSE) begin
          state_nx_s    = PAUSED;
          resume_b_nx_s = 1'b0;
        end else if (TICK && (TIME_A == ONE_V)) begin
          time_a_nx_s = {TIME_W{1'b0}};
          flag_a_nx_s = 1'b1;
          state_nx_s  = DONE;
        end else if (BTN_A) begin
          time_a_nx_s  = add_inc(TIME_A, TICK);
          state_nx_s   = RUN_B;
          pre_clr_nx_s = ~PRE_CLR;
        end else if (TICK) begin
          time_a_nx_s = TIME_A - ONE_V;
        end else begin
          state_nx_s = RUN_A;
        end
      end
      RUN_B: begin
        if (PAUSE) begin
          state_nx_s    = PAUSED;
          resume_b_nx_s = 1'b1;
        end else if (TICK && (TIME_B == ONE_V)) begin
          time_b_nx_s = {TIME_W{1'b0}};
          flag_b_nx_s = 1'b1;
          state_nx_s  = DONE;
        end else if (BTN_B) begin
          time_b_nx_s  = add_inc(TIME_B, TICK);
          state_nx_s   = RUN_A;
          pre_clr_nx_s = ~PRE_CLR;
        end else if (TICK) begin
          time_b_nx_s = TIME_B - ONE_V;
        end else begin
          state_nx_s = RUN_B;
        end
      end
      PAUSED: begin
        if (START) begin
          state_nx_s  = IDLE;
          time_a_nx_s = INIT_V;
          time_b_nx_s = INIT_V;
          flag_a_nx_s = 1'b0;
          flag_b_nx_s = 1'b0;
        end else if (PAUSE) begin
          state_nx_s   = resume_b_r ? RUN_B : RUN_A;
          pre_clr_nx_s = ~PRE_CLR;
        end else begin
          state_nx_s = PAUSED;
        end
      end
      DONE: begin
        if (START) begin
          state_nx_s  = IDLE;
          time_a_nx_s = INIT_V;
          time_b_nx_s = INIT_V;
          flag_a_nx_s = 1'b0;
          flag_b_nx_s = 1'b0;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: begin
        state_nx_s  = IDLE;
        time_a_nx_s = INIT_V;
        time_b_nx_s = INIT_V;
        flag_a_nx_s = 1'b0;
        flag_b_nx_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs; CLR aborts everything asynchronously.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_r    <= IDLE;
      resume_b_r <= 1'b0;
      TIME_A     <= INIT_V;
      TIME_B     <= INIT_V;
      FLAG_A     <= 1'b0;
      FLAG_B     <= 1'b0;
      ACTIVE_A   <= 1'b0;
      ACTIVE_B   <= 1'b0;
      PRE_CE     <= 1'b0;
      PRE_CLR    <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      resume_b_r <= resume_b_nx_s;
      TIME_A     <= time_a_nx_s;
      TIME_B     <= time_b_nx_s;
      FLAG_A     <= flag_a_nx_s;
      FLAG_B     <= flag_b_nx_s;
      ACTIVE_A   <= (state_nx_s == RUN_A);
      ACTIVE_B   <= (state_nx_s == RUN_B);
      PRE_CE     <= (state_nx_s == RUN_A) || (state_nx_s == RUN_B);
      PRE_CLR    <= pre_clr_nx_s;
    end
  end

endmodule

// File: tb/tb_chess_turn_ctrl.sv
// Directed bench for chess_turn_ctrl: main instance (W=8, init 5, inc 2) and a
// saturation instance (W=8, init 254, inc 5).
module tb_chess_turn_ctrl;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic       tick = 1'b0, start = 1'b0, btn_a = 1'b0, btn_b = 1'b0, pause = 1'b0;
  logic [7:0] time_a, time_b;
  logic       act_a, act_b, flag_a, flag_b, pre_ce, pre_clr;

  logic       s_start = 1'b0, s_btn_a = 1'b0;
  logic [7:0] s_time_a, s_time_b;
  logic       s_act_a, s_act_b, s_flag_a, s_flag_b, s_pre_ce, s_pre_clr;

  int n_checks = 0;
  int n_errors = 0;

  chess_turn_ctrl #(.TIME_W(8), .INIT_TIME(5), .INC(2)) dut (
    .CLK(CLK), .CLR(CLR), .TICK(tick), .START(start), .BTN_A(btn_a), .BTN_B(btn_b),
    .PAUSE(pause), .TIME_A(time_a), .TIME_B(time_b), .ACTIVE_A(act_a), .ACTIVE_B(act_b),
    .FLAG_A(flag_a), .FLAG_B(flag_b), .PRE_CE(pre_ce), .PRE_CLR(pre_clr)
  );

  chess_turn_ctrl #(.TIME_W(8), .INIT_TIME(254), .INC(5)) dut_sat (
    .CLK(CLK), .CLR(CLR), .TICK(1'b0), .START(s_start), .BTN_A(s_btn_a), .BTN_B(1'b0),
    .PAUSE(1'b0), .TIME_A(s_time_a), .TIME_B(s_time_b), .ACTIVE_A(s_act_a), .ACTIVE_B(s_act_b),
    .FLAG_A(s_flag_a), .FLAG_B(s_flag_b), .PRE_CE(s_pre_ce), .PRE_CLR(s_pre_clr)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock with the given inputs held, then sample 1 ns after the edge.
  task automatic cyc(input logic t, input logic s, input logic ba, input logic bb, input logic p);
    tick = t; start = s; btn_a = ba; btn_b = bb; pause = p;
    @(posedge CLK);
    #1;
    tick = 1'b0; start = 1'b0; btn_a = 1'b0; btn_b = 1'b0; pause = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_time_a", time_a, 5);
    chk("rst_time_b", time_b, 5);
    chk("rst_act", {act_a, act_b, flag_a, flag_b, pre_ce, pre_clr}, 0);
    chk("rst_sat_time_a", s_time_a, 254);
    CLR = 1'b0;
    @(posedge CLK); #1;

    // 1: start, three ticks
    cyc(0, 1, 0, 0, 0);
    chk("start_act_a", act_a, 1);
    chk("start_pre_clr", pre_clr, 1);
    chk("start_pre_ce", pre_ce, 1);
    cyc(1, 0, 0, 0, 0);
    chk("pre_clr_one_cycle", pre_clr, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("t1_time_a", time_a, 2);
    chk("t1_time_b", time_b, 5);
    chk("t1_act_pre_ce", {act_a, pre_ce}, 2'b11);

    // 2: handover with increment; BTN_B with coincident tick
    cyc(0, 0, 1, 0, 0);
    chk("t2_time_a", time_a, 4);
    chk("t2_act", {act_a, act_b}, 2'b01);
    chk("t2_pre_clr", pre_clr, 1);
    cyc(0, 0, 1, 0, 0);
    chk("t2_wrong_btn_ignored", {act_b, time_a, pre_clr}, {1'b1, 8'd4, 1'b0});
    cyc(1, 0, 0, 1, 0);
    chk("t2_time_b", time_b, 6);
    chk("t2_back_to_a", {act_a, act_b, pre_clr}, 3'b101);

    // 3: time-out beats the button, DONE freezes, START reloads
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("t3_time_a_one", time_a, 1);
    cyc(1, 0, 1, 0, 0);
    chk("t3_timeout_time_a", time_a, 0);
    chk("t3_flag", {flag_a, flag_b}, 2'b10);
    chk("t3_stopped", {act_a, act_b, pre_ce, pre_clr}, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    chk("t3_done_hold", {time_a, time_b, flag_a, act_a, act_b}, {8'd0, 8'd6, 1'b1, 2'b00});
    cyc(0, 1, 0, 0, 0);
    chk("t3_reload", {time_a, time_b}, {8'd5, 8'd5});
    chk("t3_idle", {flag_a, flag_b, act_a, act_b, pre_ce}, 0);

    // 4: immediate handover keeps PRE_CLR single-cycle; pause/resume in RUN_B
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("t4_back_to_back_pre_clr", pre_clr, 0);
    chk("t4_run_b", {act_b, time_a}, {1'b1, 8'd7});
    cyc(1, 0, 0, 0, 1);
    chk("t4_paused", {act_a, act_b, pre_ce, time_b}, {3'b000, 8'd5});
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("t4_frozen", {time_a, time_b, act_a, act_b}, {8'd7, 8'd5, 2'b00});
    cyc(0, 0, 0, 0, 1);
    chk("t4_resume", {act_a, act_b, pre_clr, pre_ce}, 4'b0111);

    // 5: increment saturates
    s_start = 1'b1; @(posedge CLK); #1; s_start = 1'b0;
    @(posedge CLK); #1;
    s_btn_a = 1'b1; @(posedge CLK); #1; s_btn_a = 1'b0;
    chk("t5_saturate", s_time_a, 255);
    chk("t5_sat_run_b", s_act_b, 1);

    // 6: asynchronous abort mid-cycle
    cyc(0, 0, 0, 1, 0);
    chk("t6_time_b", time_b, 7);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("t6_time_a_three", {act_a, time_a}, {1'b1, 8'd3});
    #2 CLR = 1'b1;
    #1;
    chk("t6_async_time", {time_a, time_b}, {8'd5, 8'd5});
    chk("t6_async_outs", {act_a, act_b, pre_ce, pre_clr, flag_a, flag_b}, 0);
    #2 CLR = 1'b0;
    cyc(1, 0, 1, 0, 0);
    chk("t6_idle_after", {act_a, time_a}, {1'b0, 8'd5});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
